// File: rtl/adder_arbiter_if.sv
// Request, response and shared-adder signals of the
// adder arbiter, bundled with requester/arbiter views.
interface adder_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W:0]     add_s;
  logic           resp_valid;
  logic           resp_ready;
  logic [IDW-1:0] resp_id;
  logic [W:0]     resp_sum;
  logic           busy;

  modport master (
    output req_valid, req_a, req_b,
    output resp_ready, add_s,
    input  req_ready, add_a, add_b,
    input  resp_valid, resp_id, resp_sum,
    input  busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  resp_ready, add_s,
    output req_ready, add_a, add_b,
    output resp_valid, resp_id, resp_sum,
    output busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one combinational adder
// among N requesters, with valid/ready response.
module adder_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int ADD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);
  localparam int LW  = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic [LW-1:0]  lat_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           vld_q;
  logic [IDW-1:0] id_q;
  logic [W:0]     sum_q;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] scan_idx;
  logic           gnt_any;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + i) % N);
      if (!gnt_any && bus.req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  assign rr_ptr_d = IDW'((int'(gnt_id) + 1) % N);

  assign bus.req_ready =
    (rst_n && state_q == IDLE && gnt_any)
      ? (N'(1) << gnt_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      lat_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      sum_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            a_q      <= bus.req_a[gnt_id*W +: W];
            b_q      <= bus.req_b[gnt_id*W +: W];
            id_q     <= gnt_id;
            lat_q    <= LW'(ADD_LAT);
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          lat_q <= lat_q - 1'b1;
          if (lat_q == LW'(1)) begin
            sum_q   <= bus.add_s;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  assign bus.resp_valid = vld_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
